// File: rtl/seg7_display_mux.sv
// seg7_display_mux: time-multiplexed 4-digit common-anode seven-segment driver.
// Scans MM:SS BCD digits right to left and blinks the selected pair while adjusting.
// Anodes, segments and decimal point are active-low and registered.
// Optional feature macro: DISP_COLON_EN lights the decimal point on digit 2 (MM.SS).
module seg7_display_mux #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_1,
  input  logic [3:0] min_2,
  input  logic [3:0] sec_1,
  input  logic [3:0] sec_2,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  logic [3:0] digit;
  logic [6:0] seg_next;
  logic [3:0] an_next;
  logic       blank;
  logic       dp_next;

  // Pick the digit for the current scan slot (idx 0 is the rightmost digit).
  always_comb begin
    digit = sec_2;
    case (idx)
      2'd0: digit = sec_2;
      2'd1: digit = sec_1;
      2'd2: digit = min_2;
      2'd3: digit = min_1;
      default: digit = sec_2;
    endcase
  end

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  always_comb begin
    seg_next = 7'b0111111;
    case (digit)
      4'd0: seg_next = 7'b1000000;
      4'd1: seg_next = 7'b1111001;
      4'd2: seg_next = 7'b0100100;
      4'd3: seg_next = 7'b0110000;
      4'd4: seg_next = 7'b0011001;
      4'd5: seg_next = 7'b0010010;
      4'd6: seg_next = 7'b0000010;
      4'd7: seg_next = 7'b1111000;
      4'd8: seg_next = 7'b0000000;
      4'd9: seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase
  end

  // Blank the slot when it belongs to the selected pair during the off blink phase.
  always_comb begin
    blank   = adj & blink_ph & (sel ? ~idx[1] : idx[1]);
    an_next = blank ? '1 : ~(4'b0001 << idx);
`ifdef DISP_COLON_EN
    dp_next = ~((idx == 2'd2) & ~blank);
`else
    dp_next = 1'b1;
`endif
  end

  // Scan/blink timebases and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_ph    <= 1'b0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
    end else begin
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (!adj) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_display_mux.sv
// tb_seg7_display_mux: randomized self-checking bench for seg7_display_mux.
// Expected outputs come from an elapsed-cycle model of the scan and blink timing.
module tb_seg7_display_mux;

  localparam int unsigned R = 4;
  localparam int unsigned B = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] min_1 = '0, min_2 = '0, sec_1 = '0, sec_2 = '0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, consecutive adj=1 edges.
  int t = 0;
  int a = 0;

  logic [6:0] dec_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  seg7_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .min_1(min_1), .min_2(min_2), .sec_1(sec_1), .sec_2(sec_2),
    .adj(adj), .sel(sel),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d a=%0d at %0t)", tag, got, exp, t, a, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int d);
    if (d > 9) return 7'b0111111;
    return dec_tab[d];
  endfunction

  // One clock: predict from model + held inputs, advance model, check after the edge.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int slot, d;
    bit off;
    @(posedge clk);
    if (rst) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      t = 0; a = 0;
    end else begin
      slot = (t / R) % 4;
      case (slot)
        0: d = int'(sec_2);
        1: d = int'(sec_1);
        2: d = int'(min_2);
        default: d = int'(min_1);
      endcase
      off   = adj && ((a / B) % 2 == 1) && (sel ? (slot < 2) : (slot >= 2));
      e_seg = exp_seg(d);
      e_an  = off ? 4'b1111 : 4'(~(1 << slot));
`ifdef DISP_COLON_EN
      e_dp  = !(slot == 2 && !off);
`else
      e_dp  = 1'b1;
`endif
      t++;
      a = adj ? a + 1 : 0;
    end
    #1;
    check(rst ? "an_rst" : "an", 32'(an), 32'(e_an));
    check(rst ? "seg_rst" : "seg", 32'(seg), 32'(e_seg));
    check(rst ? "dp_rst" : "dp", 32'(dp), 32'(e_dp));
  endtask

  initial begin
    // Reset held for three clocks.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Fixed digits 12:34, plain scanning.
    min_1 = 4'd1; min_2 = 4'd2; sec_1 = 4'd3; sec_2 = 4'd4;
    repeat (32) step();

    // Blink seconds pair, then minutes pair.
    adj = 1'b1; sel = 1'b1;
    repeat (70) step();
    sel = 1'b0;
    repeat (70) step();
    adj = 1'b0;

    // Non-decimal code on the rightmost digit.
    sec_2 = 4'hC;
    repeat (20) step();

    // Reset pulse while digit 2 is being shown.
    for (int k = 0; k < 16 && ((t / R) % 4) != 2; k++) step();
    check("reached_slot2", (t / R) % 4, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (12) step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: min_1 = 4'($urandom);
          1: min_2 = 4'($urandom);
          2: sec_1 = 4'($urandom);
          default: sec_2 = 4'($urandom);
        endcase
      end
      if ($urandom_range(0, 59) == 0) adj = ~adj;
      if ($urandom_range(0, 29) == 0) sel = ~sel;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
